// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: instruction memory, control inputs from decode/exception
// logic, and the IF/ID register contents presented to decode.
interface pc_fetch_if;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        is_branchD;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] PCD;
  logic [31:0] InstrD;
  logic [31:0] PC8D;
  logic        validD;
  logic        excD;
  logic [4:0]  exc_codeD;
  logic        bdD;

  // Fetch unit side
  modport master (
    output PC, PCD, InstrD, PC8D, validD, excD, exc_codeD, bdD,
    input  Instr, stall, redirect, redirect_pc, is_branchD, exc_req, eret, epc
  );

  // Pipeline/environment side
  modport slave (
    input  PC, PCD, InstrD, PC8D, validD, excD, exc_codeD, bdD,
    output Instr, stall, redirect, redirect_pc, is_branchD, exc_req, eret, epc
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: program counter with prioritized next-PC
// selection, fetch address fault detection (AdEL), and the IF/ID register.
module pc_fetch #(
  parameter logic [31:0] START_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int unsigned SIZE       = 4096
) (
  input logic        clk,
  input logic        reset,
  pc_fetch_if.master bus
);

  // Last valid byte address of instruction memory, 33 bits so it cannot wrap.
  localparam logic [32:0] LAST_ADDR = {1'b0, START_PC} + (33'(SIZE) * 33'd4) - 33'd1;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

  logic [31:0] r_pc;
  logic [31:0] r_pcd;
  logic [31:0] r_instrd;
  logic [31:0] r_pc8d;
  logic        r_validd;
  logic        r_excd;
  logic [4:0]  r_exc_coded;
  logic        r_bdd;

  logic [31:0] w_next_pc;
  logic        w_fault;
  logic        w_flush;

  assign w_flush = bus.exc_req | bus.eret;

  // Fetch fault: misaligned, below the memory base, or beyond its end.
  assign w_fault = (r_pc[1:0] != 2'b00)
                 | ({1'b0, r_pc} < {1'b0, START_PC})
                 | ({1'b0, r_pc} > LAST_ADDR);

  // Next-PC selection in strict priority order.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (bus.exc_req)       w_next_pc = HANDLER_PC;
    else if (bus.eret)     w_next_pc = bus.epc;
    else if (bus.stall)    w_next_pc = r_pc;
    else if (bus.redirect) w_next_pc = bus.redirect_pc;
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= START_PC;
    else       r_pc <= w_next_pc;
  end

  // IF/ID register: flush on exception entry/return, hold on stall, else capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcd       <= '0;
      r_instrd    <= '0;
      r_pc8d      <= '0;
      r_validd    <= 1'b0;
      r_excd      <= 1'b0;
      r_exc_coded <= '0;
      r_bdd       <= 1'b0;
    end else if (w_flush) begin
      r_pcd       <= '0;
      r_instrd    <= '0;
      r_pc8d      <= '0;
      r_validd    <= 1'b0;
      r_excd      <= 1'b0;
      r_exc_coded <= '0;
      r_bdd       <= 1'b0;
    end else if (!bus.stall) begin
      r_pcd       <= r_pc;
      r_pc8d      <= r_pc + 32'd8;
      r_validd    <= 1'b1;
      r_bdd       <= bus.is_branchD;
      r_instrd    <= w_fault ? 32'h0 : bus.Instr;
      r_excd      <= w_fault;
      r_exc_coded <= w_fault ? EXC_ADEL : 5'd0;
    end
  end

  assign bus.PC        = r_pc;
  assign bus.PCD       = r_pcd;
  assign bus.InstrD    = r_instrd;
  assign bus.PC8D      = r_pc8d;
  assign bus.validD    = r_validd;
  assign bus.excD      = r_excd;
  assign bus.exc_codeD = r_exc_coded;
  assign bus.bdD       = r_bdd;

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: directed scenarios followed by randomized control
// traffic, all checked against a cycle-level reference model.
module tb_pc_fetch;

  localparam logic [31:0] START_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam int unsigned SIZE       = 4096;

  logic clk;
  logic reset;
  pc_fetch_if bus ();

  pc_fetch #(
    .START_PC  (START_PC),
    .HANDLER_PC(HANDLER_PC),
    .SIZE      (SIZE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a recognizable function of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1234};
  endfunction

  assign bus.Instr = instr_of(bus.PC);

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc, m_pcd, m_instrd, m_pc8d;
  logic        m_valid, m_exc, m_bd;
  logic [4:0]  m_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (la % 4 != 0) || (la < longint'(START_PC)) ||
           (la >= longint'(START_PC) + 4 * longint'(SIZE));
  endfunction

  task automatic model_reset();
    m_pc = START_PC; m_pcd = '0; m_instrd = '0; m_pc8d = '0;
    m_valid = 1'b0; m_exc = 1'b0; m_bd = 1'b0; m_code = '0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".PC"},        bus.PC,               m_pc);
    chk({ctx, ".PCD"},       bus.PCD,              m_pcd);
    chk({ctx, ".InstrD"},    bus.InstrD,           m_instrd);
    chk({ctx, ".PC8D"},      bus.PC8D,             m_pc8d);
    chk({ctx, ".validD"},    32'(bus.validD),      32'(m_valid));
    chk({ctx, ".excD"},      32'(bus.excD),        32'(m_exc));
    chk({ctx, ".exc_codeD"}, 32'(bus.exc_codeD),   32'(m_code));
    chk({ctx, ".bdD"},       32'(bus.bdD),         32'(m_bd));
  endtask

  // One clock: compute model's next state from current inputs, clock, compare.
  task automatic step(input string ctx);
    logic [31:0] n_pc;
    if (bus.exc_req)       n_pc = HANDLER_PC;
    else if (bus.eret)     n_pc = bus.epc;
    else if (bus.stall)    n_pc = m_pc;
    else if (bus.redirect) n_pc = bus.redirect_pc;
    else                   n_pc = m_pc + 32'd4;
    if (bus.exc_req || bus.eret) begin
      m_pcd = '0; m_instrd = '0; m_pc8d = '0;
      m_valid = 1'b0; m_exc = 1'b0; m_bd = 1'b0; m_code = '0;
    end else if (!bus.stall) begin
      m_pcd   = m_pc;
      m_pc8d  = m_pc + 32'd8;
      m_valid = 1'b1;
      m_bd    = bus.is_branchD;
      if (is_fault(m_pc)) begin
        m_instrd = 32'h0; m_exc = 1'b1; m_code = 5'd4;
      end else begin
        m_instrd = instr_of(m_pc); m_exc = 1'b0; m_code = 5'd0;
      end
    end
    m_pc = n_pc;
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.is_branchD = 1'b0; bus.exc_req = 1'b0; bus.eret = 1'b0; bus.epc = '0;
  endtask

  // Reset pulse starting mid-cycle; PC must snap to START_PC before any edge.
  task automatic pulse_reset(input string ctx);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    chk({ctx, ".PC_async"},     bus.PC,          START_PC);
    chk({ctx, ".validD_async"}, 32'(bus.validD), 32'd0);
    check_all(ctx);
    @(posedge clk);
    #1;
    check_all({ctx, "_held"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] hold_pc, hold_instr;

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;

    // Free run: 3000 -> 3004 -> 3008 -> 300C
    step("run1"); chk("run1.PC_k", bus.PC, 32'h3004); chk("run1.validD_k", 32'(bus.validD), 32'd1);
    step("run2"); chk("run2.PC_k", bus.PC, 32'h3008); chk("run2.PC8D_k", bus.PC8D, 32'h300C);
    step("run3"); chk("run3.PC_k", bus.PC, 32'h300C); chk("run3.PCD_k", bus.PCD, 32'h3008);

    // Redirect at PC=0x3008 with branch in decode
    pulse_reset("rst2");
    step("r1"); step("r2");
    bus.redirect = 1'b1; bus.redirect_pc = 32'h3100; bus.is_branchD = 1'b1;
    step("redir");
    chk("redir.PC_k", bus.PC, 32'h3100); chk("redir.PCD_k", bus.PCD, 32'h3008);
    chk("redir.bdD_k", 32'(bus.bdD), 32'd1);
    idle_inputs();
    step("after_redir");

    // Stall two cycles with redirect asserted: everything holds
    hold_pc = bus.PC; hold_instr = bus.InstrD;
    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h3400;
    step("stall1"); chk("stall1.PC_k", bus.PC, hold_pc); chk("stall1.InstrD_k", bus.InstrD, hold_instr);
    step("stall2"); chk("stall2.PC_k", bus.PC, hold_pc); chk("stall2.InstrD_k", bus.InstrD, hold_instr);
    idle_inputs();
    step("post_stall");

    // Exception entry beats stall and eret
    bus.exc_req = 1'b1; bus.stall = 1'b1; bus.eret = 1'b1; bus.epc = 32'h3010;
    step("exc");
    chk("exc.PC_k", bus.PC, HANDLER_PC); chk("exc.validD_k", 32'(bus.validD), 32'd0);
    chk("exc.InstrD_k", bus.InstrD, 32'h0);
    idle_inputs();
    step("handler");

    // Exception return
    bus.eret = 1'b1; bus.epc = 32'h3010;
    step("eret");
    chk("eret.PC_k", bus.PC, 32'h3010); chk("eret.PCD_k", bus.PCD, 32'h0);
    idle_inputs();

    // Faulting fetch addresses, then the top-of-memory boundary
    bus.redirect = 1'b1; bus.redirect_pc = 32'h3002; step("f_a");
    bus.redirect_pc = 32'h2FFC; step("f_b");
    chk("f_misal.excD_k", 32'(bus.excD), 32'd1); chk("f_misal.PCD_k", bus.PCD, 32'h3002);
    bus.redirect_pc = 32'h7000; step("f_c");
    chk("f_low.code_k", 32'(bus.exc_codeD), 32'd4); chk("f_low.PCD_k", bus.PCD, 32'h2FFC);
    bus.redirect_pc = 32'h6FFC; step("f_d");
    chk("f_high.InstrD_k", bus.InstrD, 32'h0); chk("f_high.PCD_k", bus.PCD, 32'h7000);
    idle_inputs();
    step("top_last");
    chk("top_last.excD_k", 32'(bus.excD), 32'd0); chk("top_last.PCD_k", bus.PCD, 32'h6FFC);
    step("top_over");
    chk("top_over.excD_k", 32'(bus.excD), 32'd1); chk("top_over.PCD_k", bus.PCD, 32'h7000);

    // Reset in the middle of a stall/redirect
    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h3500;
    pulse_reset("rst_mid");
    idle_inputs();
    step("rst_mid_first");
    chk("rst_mid_first.PCD_k", bus.PCD, START_PC);

    // Randomized control traffic
    for (int i = 0; i < 400; i++) begin
      bus.exc_req    = ($urandom_range(0, 99) < 3);
      bus.eret       = ($urandom_range(0, 99) < 4);
      bus.stall      = ($urandom_range(0, 99) < 20);
      bus.redirect   = ($urandom_range(0, 99) < 25);
      bus.is_branchD = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8)
        bus.redirect_pc = START_PC + 4 * 32'($urandom_range(0, SIZE - 1));
      else
        bus.redirect_pc = $urandom;
      bus.epc = START_PC + 4 * 32'($urandom_range(0, SIZE));
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
